// File: rtl/jesd204_rx_cgs_ctrl.sv
// Per-lane JESD204 receive CGS controller: owns the decoder running disparity,
// sequences INIT/CHECK/DATA, drives SYNC~ and tracks decode errors.
module jesd204_rx_cgs_ctrl #(
  parameter int CGS_K_COUNT = 4,
  parameter int ERR_THRESH  = 3,
  parameter int CLEAN_RUN   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [7:0] phy_char,
  input  logic       phy_charisk,
  input  logic       phy_notintable,
  input  logic       phy_disperr,
  input  logic       dec_disparity_s,
  output logic       dec_disparity,
  output logic       sync_n,
  output logic [1:0] cgs_state,
  output logic       data_start,
  output logic       err_event,
  output logic [7:0] err_total
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  localparam logic [3:0] K_TARGET     = 4'(CGS_K_COUNT);
  localparam logic [3:0] ERR_TARGET   = 4'(ERR_THRESH);
  localparam logic [7:0] CLEAN_TARGET = 8'(CLEAN_RUN);

  logic [3:0] k_cnt, k_cnt_nx;
  logic [3:0] err_cnt, err_cnt_nx;
  logic [7:0] clean_cnt, clean_cnt_nx;
  logic [1:0] state_nx;
  logic       start_nx, event_nx;
  logic       valid_k, err;

  assign valid_k = phy_charisk & (phy_char == 8'hBC) & ~phy_notintable & ~phy_disperr;
  assign err     = phy_notintable | phy_disperr;

  // Next-state logic; a threshold hit clears every counter on its way back to INIT.
  always_comb begin
    state_nx     = cgs_state;
    k_cnt_nx     = k_cnt;
    err_cnt_nx   = err_cnt;
    clean_cnt_nx = clean_cnt;
    start_nx     = 1'b0;
    event_nx     = 1'b0;
    if (!enable) begin
      state_nx     = ST_INIT;
      k_cnt_nx     = 4'd0;
      err_cnt_nx   = 4'd0;
      clean_cnt_nx = 8'd0;
    end else begin
      case (cgs_state)
        ST_INIT: begin
          err_cnt_nx   = 4'd0;
          clean_cnt_nx = 8'd0;
          if (valid_k) begin
            if (k_cnt + 4'd1 == K_TARGET) begin
              state_nx = ST_CHECK;
              k_cnt_nx = 4'd0;
            end else begin
              k_cnt_nx = k_cnt + 4'd1;
            end
          end else begin
            k_cnt_nx = 4'd0;
          end
        end
        ST_CHECK: begin
          if (err) begin
            if (err_cnt + 4'd1 == ERR_TARGET) begin
              state_nx     = ST_INIT;
              event_nx     = 1'b1;
              k_cnt_nx     = 4'd0;
              err_cnt_nx   = 4'd0;
              clean_cnt_nx = 8'd0;
            end else begin
              err_cnt_nx = err_cnt + 4'd1;
            end
          end else if (!valid_k) begin
            state_nx = ST_DATA;
            start_nx = 1'b1;
          end
        end
        ST_DATA: begin
          // An error always beats a completing clean run.
          if (err) begin
            clean_cnt_nx = 8'd0;
            if (err_cnt + 4'd1 == ERR_TARGET) begin
              state_nx   = ST_INIT;
              event_nx   = 1'b1;
              k_cnt_nx   = 4'd0;
              err_cnt_nx = 4'd0;
            end else begin
              err_cnt_nx = err_cnt + 4'd1;
            end
          end else if (clean_cnt + 8'd1 == CLEAN_TARGET) begin
            clean_cnt_nx = 8'd0;
            if (err_cnt != 4'd0) begin
              err_cnt_nx = err_cnt - 4'd1;
            end
          end else begin
            clean_cnt_nx = clean_cnt + 8'd1;
          end
        end
        default: begin
          state_nx     = ST_INIT;
          k_cnt_nx     = 4'd0;
          err_cnt_nx   = 4'd0;
          clean_cnt_nx = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cgs_state     <= ST_INIT;
      k_cnt         <= 4'd0;
      err_cnt       <= 4'd0;
      clean_cnt     <= 8'd0;
      sync_n        <= 1'b0;
      dec_disparity <= 1'b0;
      data_start    <= 1'b0;
      err_event     <= 1'b0;
      err_total     <= 8'd0;
    end else begin
      cgs_state     <= state_nx;
      k_cnt         <= k_cnt_nx;
      err_cnt       <= err_cnt_nx;
      clean_cnt     <= clean_cnt_nx;
      sync_n        <= (state_nx != ST_INIT);
      dec_disparity <= enable & dec_disparity_s;
      data_start    <= start_nx;
      err_event     <= event_nx;
      if (enable && err && err_total != 8'hFF) begin
        err_total <= err_total + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_jesd204_rx_cgs_ctrl.sv
// Self-checking bench for jesd204_rx_cgs_ctrl: vector table, directed
// corner-case sequences and a randomized run against a behavioural model.
module tb_jesd204_rx_cgs_ctrl;

  localparam int CGS_K = 4;
  localparam int THR   = 3;
  localparam int CLEAN = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] phy_char = 8'h00;
  logic       phy_charisk = 1'b0;
  logic       phy_notintable = 1'b0;
  logic       phy_disperr = 1'b0;
  logic       dec_disparity_s = 1'b0;
  logic       dec_disparity;
  logic       sync_n;
  logic [1:0] cgs_state;
  logic       data_start;
  logic       err_event;
  logic [7:0] err_total;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 = INIT, 1 = CHECK, 2 = DATA.
  int m_mode, m_k, m_err, m_clean, m_total;
  int m_sync, m_disp, m_start, m_event;

  typedef struct {
    logic       en;
    logic [7:0] ch;
    logic       k;
    logic       nit;
    logic       de;
    logic       ds;
    logic [1:0] st;
    logic       sy;
    logic       dd;
    logic       start;
    logic       evt;
  } vec_t;

  vec_t vecs[13];

  jesd204_rx_cgs_ctrl #(
    .CGS_K_COUNT(CGS_K),
    .ERR_THRESH (THR),
    .CLEAN_RUN  (CLEAN)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .phy_char       (phy_char),
    .phy_charisk    (phy_charisk),
    .phy_notintable (phy_notintable),
    .phy_disperr    (phy_disperr),
    .dec_disparity_s(dec_disparity_s),
    .dec_disparity  (dec_disparity),
    .sync_n         (sync_n),
    .cgs_state      (cgs_state),
    .data_start     (data_start),
    .err_event      (err_event),
    .err_total      (err_total)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    m_mode = 0; m_k = 0; m_err = 0; m_clean = 0; m_total = 0;
    m_sync = 0; m_disp = 0; m_start = 0; m_event = 0;
  endtask

  task automatic modelStep(input logic en, input logic [7:0] ch, input logic k,
                           input logic nit, input logic de, input logic ds);
    bit vk, e;
    vk = k && (ch == 8'hBC) && !nit && !de;
    e  = nit || de;
    m_start = 0;
    m_event = 0;
    if (en && e && m_total < 255) m_total++;
    m_disp = en ? int'(ds) : 0;
    if (!en) begin
      m_mode = 0; m_k = 0; m_err = 0; m_clean = 0;
    end else if (m_mode == 0) begin
      if (vk) begin
        m_k++;
        if (m_k == CGS_K) begin m_mode = 1; m_k = 0; end
      end else begin
        m_k = 0;
      end
    end else if (e) begin
      m_err++;
      m_clean = 0;
      if (m_err == THR) begin
        m_mode = 0; m_event = 1; m_err = 0; m_k = 0;
      end
    end else if (m_mode == 1) begin
      if (!vk) begin m_mode = 2; m_start = 1; end
    end else begin
      m_clean++;
      if (m_clean == CLEAN) begin
        m_clean = 0;
        if (m_err > 0) m_err--;
      end
    end
    m_sync = (m_mode != 0) ? 1 : 0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, ".cgs_state"}, int'(cgs_state), m_mode);
    checkOutput({tag, ".sync_n"}, int'(sync_n), m_sync);
    checkOutput({tag, ".dec_disparity"}, int'(dec_disparity), m_disp);
    checkOutput({tag, ".data_start"}, int'(data_start), m_start);
    checkOutput({tag, ".err_event"}, int'(err_event), m_event);
    checkOutput({tag, ".err_total"}, int'(err_total), m_total);
  endtask

  // Drive one character, let one rising edge pass, advance the model.
  task automatic applyStimulus(input logic en, input logic [7:0] ch, input logic k,
                               input logic nit, input logic de, input logic ds);
    enable = en; phy_char = ch; phy_charisk = k;
    phy_notintable = nit; phy_disperr = de; dec_disparity_s = ds;
    @(posedge clk);
    #1;
    modelStep(en, ch, k, nit, de, ds);
  endtask

  task automatic applyReset();
    resetn = 1'b0;
    enable = 1'b0; phy_char = 8'h00; phy_charisk = 1'b0;
    phy_notintable = 1'b0; phy_disperr = 1'b0; dec_disparity_s = 1'b0;
    modelReset();
    #2;
    checkOutput("reset.cgs_state", int'(cgs_state), 0);
    checkOutput("reset.sync_n", int'(sync_n), 0);
    checkOutput("reset.dec_disparity", int'(dec_disparity), 0);
    checkOutput("reset.data_start", int'(data_start), 0);
    checkOutput("reset.err_event", int'(err_event), 0);
    checkOutput("reset.err_total", int'(err_total), 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic sendK(input string tag);
    applyStimulus(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    checkAgainstModel(tag);
  endtask

  task automatic sendClean(input string tag);
    applyStimulus(1'b1, 8'($urandom_range(0, 187)), 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    checkAgainstModel(tag);
  endtask

  task automatic sendErr(input string tag);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    checkAgainstModel(tag);
  endtask

  task automatic reachData(input string tag);
    for (int i = 0; i < CGS_K; i++) sendK(tag);
    sendClean(tag);
    checkOutput({tag, ".in_data"}, int'(cgs_state), 2);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};

    applyReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].en, vecs[i].ch, vecs[i].k, vecs[i].nit, vecs[i].de, vecs[i].ds);
      checkOutput($sformatf("vec%0d.cgs_state", i), int'(cgs_state), int'(vecs[i].st));
      checkOutput($sformatf("vec%0d.sync_n", i), int'(sync_n), int'(vecs[i].sy));
      checkOutput($sformatf("vec%0d.dec_disparity", i), int'(dec_disparity), int'(vecs[i].dd));
      checkOutput($sformatf("vec%0d.data_start", i), int'(data_start), int'(vecs[i].start));
      checkOutput($sformatf("vec%0d.err_event", i), int'(err_event), int'(vecs[i].evt));
    end

    // Three errors with only three clean characters between them: no decay, threshold hit.
    applyReset();
    reachData("thresh");
    for (int i = 0; i < 3; i++) begin
      sendErr("thresh");
      if (i < 2) for (int j = 0; j < 3; j++) sendClean("thresh");
    end
    checkOutput("thresh.err_event", int'(err_event), 1);
    checkOutput("thresh.cgs_state", int'(cgs_state), 0);
    checkOutput("thresh.sync_n", int'(sync_n), 0);
    checkOutput("thresh.err_total", int'(err_total), 3);

    // One error per full clean run decays away, so the lane stays in DATA.
    applyReset();
    reachData("decay");
    for (int i = 0; i < 8; i++) begin
      sendErr("decay");
      for (int j = 0; j < CLEAN; j++) sendClean("decay");
      checkOutput("decay.cgs_state", int'(cgs_state), 2);
    end
    sendErr("collide");
    for (int j = 0; j < CLEAN - 1; j++) sendClean("collide");
    sendErr("collide");
    checkOutput("collide.still_data", int'(cgs_state), 2);
    for (int j = 0; j < CLEAN - 1; j++) sendClean("collide");
    sendErr("collide");
    checkOutput("collide.err_event", int'(err_event), 1);
    checkOutput("collide.cgs_state", int'(cgs_state), 0);

    // Enable falls together with what would be the threshold error.
    applyReset();
    reachData("disable");
    sendErr("disable");
    sendErr("disable");
    applyStimulus(1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    checkAgainstModel("disable");
    checkOutput("disable.err_event", int'(err_event), 0);
    checkOutput("disable.sync_n", int'(sync_n), 0);
    checkOutput("disable.dec_disparity", int'(dec_disparity), 0);
    checkOutput("disable.err_total", int'(err_total), 2);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkAgainstModel("saturate");
    checkOutput("saturate.err_total", int'(err_total), 255);

    // Randomized traffic against the model.
    applyReset();
    for (int i = 0; i < 3000; i++) begin
      logic en, k, nit, de, ds;
      logic [7:0] ch;
      en  = ($urandom_range(0, 31) != 0);
      k   = ($urandom_range(0, 1) == 1);
      ch  = ($urandom_range(0, 3) != 0) ? 8'hBC : 8'($urandom);
      nit = ($urandom_range(0, 15) == 0);
      de  = ($urandom_range(0, 15) == 0);
      ds  = 1'($urandom_range(0, 1));
      applyStimulus(en, ch, k, nit, de, ds);
      checkAgainstModel("random");
      checkOutput("random.pulse_exclusive", int'(data_start & err_event), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
